// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module   : y86_pkg
// Brief    : Shared Y86-64 constants, F->D beat type and pipe-register states.
// Revision : 1.0 - initial release
// ============================================================================
package y86_pkg;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] IHALT    = 4'h0;
  localparam logic [3:0] INOP     = 4'h1;
  localparam logic [3:0] IRRMOVQ  = 4'h2;
  localparam logic [3:0] IIRMOVQ  = 4'h3;
  localparam logic [3:0] IRMMOVQ  = 4'h4;
  localparam logic [3:0] IMRMOVQ  = 4'h5;
  localparam logic [3:0] IOPQ     = 4'h6;
  localparam logic [3:0] IJXX     = 4'h7;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
  } f2d_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

endpackage
`default_nettype wire

// File: rtl/d_pipe_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : d_pipe_reg_if
// Brief    : Fetch-side and decode-side handshake bundle of the F->D register.
// Revision : 1.0 - initial release
// ============================================================================
interface d_pipe_reg_if #(
  parameter int WORD_W = 64,
  parameter int STAT_W = 3,
  parameter int CODE_W = 4,
  parameter int RID_W  = 4,
  parameter int CNT_W  = 16
);
  logic              f_valid;
  logic              f_ready;
  logic [STAT_W-1:0] f_stat;
  logic [CODE_W-1:0] f_icode;
  logic [CODE_W-1:0] f_ifun;
  logic [RID_W-1:0]  f_rA;
  logic [RID_W-1:0]  f_rB;
  logic [WORD_W-1:0] f_valC;
  logic [WORD_W-1:0] f_valP;
  logic              bubble;
  logic              d_ready;
  logic              d_valid;
  logic [STAT_W-1:0] d_stat;
  logic [CODE_W-1:0] d_icode;
  logic [CODE_W-1:0] d_ifun;
  logic [RID_W-1:0]  d_rA;
  logic [RID_W-1:0]  d_rB;
  logic [WORD_W-1:0] d_valC;
  logic [WORD_W-1:0] d_valP;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output f_valid, f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
    output bubble, d_ready,
    input  f_ready, d_valid, d_stat, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP,
    input  stall_cnt, bubble_cnt
  );

  modport slave (
    input  f_valid, f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
    input  bubble, d_ready,
    output f_ready, d_valid, d_stat, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP,
    output stall_cnt, bubble_cnt
  );
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_inc,
  output logic      [WIDTH-1:0] o_count
);
  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_max = '1;

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != c_max)) begin
      r_count <= r_count + c_one;
    end
  end

  assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/d_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : d_pipe_reg
// Brief    : Y86-64 F->D pipeline register with 2-entry skid, bubble, counters.
// Revision : 1.0 - initial release
// ============================================================================
module d_pipe_reg
  import y86_pkg::*;
#(
  parameter int                WORD_W    = 64,
  parameter int                STAT_W    = 3,
  parameter int                CODE_W    = 4,
  parameter int                RID_W     = 4,
  parameter int                CNT_W     = 16,
  parameter logic [CODE_W-1:0] NOP_ICODE = INOP,
  parameter logic [STAT_W-1:0] STAT_AOK  = SAOK,
  parameter logic [RID_W-1:0]  RNONE     = REG_NONE
) (
  input wire logic    clk,
  input wire logic    rst_n,
  d_pipe_reg_if.slave bus
);
  localparam int c_beatW = STAT_W + 2 * CODE_W + 2 * RID_W + 2 * WORD_W;
  localparam logic [c_beatW-1:0] c_bubbleBeat = {
    STAT_AOK, NOP_ICODE, {CODE_W{1'b0}}, RNONE, RNONE, {WORD_W{1'b0}}, {WORD_W{1'b0}}
  };

  pipe_state_e        r_state, w_stateNext;
  logic [c_beatW-1:0] r_main, w_mainNext;
  logic [c_beatW-1:0] r_skid, w_skidNext;
  logic [c_beatW-1:0] w_fBeat;
  logic               w_fReady, w_dValid, w_inFire, w_outFire, w_stallInc;

  assign w_fBeat = {bus.f_stat, bus.f_icode, bus.f_ifun, bus.f_rA, bus.f_rB,
                    bus.f_valC, bus.f_valP};

  // Ready depends only on the state register, so a decode stall never ripples into fetch.
  assign w_fReady   = (r_state != ST_FULL);
  assign w_dValid   = (r_state != ST_EMPTY);
  assign w_inFire   = bus.f_valid & w_fReady;
  assign w_outFire  = w_dValid & bus.d_ready;
  assign w_stallInc = w_dValid & ~bus.d_ready & ~bus.bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_main  <= c_bubbleBeat;
      r_skid  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_main  <= w_mainNext;
      r_skid  <= w_skidNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_mainNext  = r_main;
    w_skidNext  = r_skid;
    if (bus.bubble) begin
      w_stateNext = ST_ONE;
      w_mainNext  = c_bubbleBeat;
      w_skidNext  = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_inFire) begin
            w_stateNext = ST_ONE;
            w_mainNext  = w_fBeat;
          end
        end
        ST_ONE: begin
          if (w_inFire && w_outFire) begin
            w_mainNext = w_fBeat;
          end else if (w_inFire) begin
            w_stateNext = ST_FULL;
            w_skidNext  = w_fBeat;
          end else if (w_outFire) begin
            w_stateNext = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Skid is always younger than main, so it moves up only once main drains.
          if (w_outFire) begin
            w_stateNext = ST_ONE;
            w_mainNext  = r_skid;
          end
        end
        default: w_stateNext = ST_EMPTY;
      endcase
    end
  end

  assign bus.f_ready = w_fReady;
  assign bus.d_valid = w_dValid;
  assign {bus.d_stat, bus.d_icode, bus.d_ifun, bus.d_rA, bus.d_rB,
          bus.d_valC, bus.d_valP} = r_main;

  sat_counter #(.WIDTH(CNT_W)) u_stallCnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_stallInc),
    .o_count (bus.stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_bubbleCnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (bus.bubble),
    .o_count (bus.bubble_cnt)
  );
endmodule
`default_nettype wire

// File: tb/tb_d_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_d_pipe_reg
// Brief    : Scoreboard bench for d_pipe_reg against a 2-deep FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_d_pipe_reg;
  import y86_pkg::*;

  localparam int MAXC16 = 65535;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  d_pipe_reg_if #(.CNT_W(16)) bus ();
  d_pipe_reg_if #(.CNT_W(2))  bus2 ();

  d_pipe_reg #(.CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  d_pipe_reg #(.CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int   nChecks = 0;
  int   nErrors = 0;
  f2d_t expQ[$];
  int   expStall = 0;
  int   expBub = 0;
  bit   monEn = 1'b0;
  f2d_t dBeat;

  assign dBeat = {bus.d_stat, bus.d_icode, bus.d_ifun, bus.d_rA, bus.d_rB,
                  bus.d_valC, bus.d_valP};

  function automatic f2d_t bubbleWord();
    return '{stat: SAOK, icode: INOP, ifun: 4'h0, rA: REG_NONE, rB: REG_NONE,
             valC: 64'd0, valP: 64'd0};
  endfunction

  function automatic f2d_t mk(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                              input logic [3:0] ra, input logic [3:0] rb,
                              input logic [63:0] vc, input logic [63:0] vp);
    return '{stat: st, icode: ic, ifun: fn, rA: ra, rB: rb, valC: vc, valP: vp};
  endfunction

  function automatic f2d_t randBeat();
    logic [2:0] st;
    case ($urandom_range(0, 3))
      0:       st = SAOK;
      1:       st = SHLT;
      2:       st = SADR;
      default: st = SINS;
    endcase
    return mk(st, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              {$urandom(), $urandom()}, {$urandom(), $urandom()});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model absorbs the beat two time units later,
  // after the monitor has retired whatever the DUT delivered this cycle.
  task automatic drive(input bit fv, input f2d_t b, input bit bub, input bit dr, output bit acc);
    int occ;
    bit inF;
    @(negedge clk);
    bus.f_valid = fv;
    {bus.f_stat, bus.f_icode, bus.f_ifun, bus.f_rA, bus.f_rB, bus.f_valC, bus.f_valP} = b;
    bus.bubble  = bub;
    bus.d_ready = dr;
    occ = expQ.size();
    acc = fv && (occ < 2);
    inF = acc && !bub;
    #2;
    if (occ > 0 && !dr && !bub && expStall < MAXC16) expStall++;
    if (bub && expBub < MAXC16) expBub++;
    if (bub) begin
      expQ.delete();
      expQ.push_back(bubbleWord());
    end else if (inF) begin
      expQ.push_back(b);
    end
  endtask

  initial begin
    int   sz;
    f2d_t e;
    forever begin
      @(negedge clk);
      #1;
      if (monEn) begin
        sz = expQ.size();
        chk("f_ready", 64'(bus.f_ready), 64'(sz < 2));
        chk("d_valid", 64'(bus.d_valid), 64'(sz > 0));
        chk("stall_cnt", 64'(bus.stall_cnt), 64'(expStall));
        chk("bubble_cnt", 64'(bus.bubble_cnt), 64'(expBub));
        if (bus.d_valid && bus.d_ready) begin
          nChecks++;
          if (sz == 0) begin
            nErrors++;
            $display("FAIL beat: got %h, expected no beat at %0t", dBeat, $time);
          end else begin
            e = expQ.pop_front();
            if (dBeat !== e) begin
              nErrors++;
              $display("FAIL beat: got %h, expected %h at %0t", dBeat, e, $time);
            end
          end
        end
      end
    end
  end

  initial begin
    f2d_t cur;
    bit   acc, pend, fv, bub, dr;
    bus.f_valid = 1'b0; bus.bubble = 1'b0; bus.d_ready = 1'b1;
    {bus.f_stat, bus.f_icode, bus.f_ifun, bus.f_rA, bus.f_rB, bus.f_valC, bus.f_valP} = '0;
    bus2.f_valid = 1'b0; bus2.bubble = 1'b0; bus2.d_ready = 1'b0;
    {bus2.f_stat, bus2.f_icode, bus2.f_ifun, bus2.f_rA, bus2.f_rB, bus2.f_valC, bus2.f_valP} = '0;

    #12;
    chk("rst d_valid", 64'(bus.d_valid), 64'd0);
    chk("rst f_ready", 64'(bus.f_ready), 64'd1);
    chk("rst stall_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("rst bubble_cnt", 64'(bus.bubble_cnt), 64'd0);
    chk("rst d_icode", 64'(bus.d_icode), 64'(INOP));
    chk("rst d_rA", 64'(bus.d_rA), 64'(REG_NONE));
    chk("rst d_stat", 64'(bus.d_stat), 64'(SAOK));
    chk("rst d_valP", bus.d_valP, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    monEn = 1'b1;

    // Single instruction, then a back-to-back stream.
    drive(1'b1, mk(SAOK, 4'h3, 4'h0, 4'hF, 4'h2, 64'd100, 64'd74), 1'b0, 1'b1, acc);
    drive(1'b0, '0, 1'b0, 1'b1, acc);
    for (int i = 1; i <= 3; i++) drive(1'b1, mk(SAOK, 4'h6, 4'h0, 4'h1, 4'h2, 64'd0, 64'(10 * i)), 1'b0, 1'b1, acc);
    drive(1'b0, '0, 1'b0, 1'b1, acc);
    drive(1'b0, '0, 1'b0, 1'b1, acc);

    // Fill the skid under a stall, then drain.
    drive(1'b1, mk(SAOK, 4'h2, 4'h0, 4'h1, 4'h2, 64'd0, 64'd10), 1'b0, 1'b0, acc);
    drive(1'b1, mk(SAOK, 4'h2, 4'h0, 4'h3, 4'h4, 64'd0, 64'd20), 1'b0, 1'b0, acc);
    repeat (3) drive(1'b1, mk(SAOK, 4'h2, 4'h0, 4'h5, 4'h6, 64'd0, 64'd30), 1'b0, 1'b0, acc);
    repeat (4) drive(1'b0, '0, 1'b0, 1'b1, acc);

    // Bubble while FULL, with a beat offered that must be dropped.
    drive(1'b1, mk(SAOK, 4'h2, 4'h0, 4'h1, 4'h2, 64'd0, 64'd1), 1'b0, 1'b0, acc);
    drive(1'b1, mk(SAOK, 4'h2, 4'h0, 4'h1, 4'h2, 64'd0, 64'd2), 1'b0, 1'b0, acc);
    drive(1'b1, mk(SAOK, 4'h2, 4'h0, 4'h1, 4'h2, 64'd0, 64'd99), 1'b1, 1'b0, acc);
    repeat (2) drive(1'b0, '0, 1'b0, 1'b1, acc);

    // Non-AOK status words pass through untouched.
    drive(1'b1, mk(SHLT, IHALT, 4'h0, 4'hF, 4'hF, 64'd0, 64'h11), 1'b0, 1'b1, acc);
    drive(1'b1, mk(SADR, 4'h5, 4'h0, 4'h3, 4'h4, 64'hDEAD_BEEF_0000_0001, 64'h12), 1'b0, 1'b1, acc);
    drive(1'b1, mk(SINS, 4'hE, 4'h7, 4'h9, 4'hA, 64'hFFFF_FFFF_FFFF_FFFF, 64'h13), 1'b0, 1'b1, acc);
    repeat (2) drive(1'b0, '0, 1'b0, 1'b1, acc);

    // Asynchronous reset while FULL takes effect before the next edge.
    drive(1'b1, mk(SAOK, 4'h2, 4'h0, 4'h1, 4'h2, 64'd0, 64'd41), 1'b0, 1'b0, acc);
    drive(1'b1, mk(SAOK, 4'h2, 4'h0, 4'h1, 4'h2, 64'd0, 64'd42), 1'b0, 1'b0, acc);
    drive(1'b0, '0, 1'b0, 1'b0, acc);
    #1;
    bus.f_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async d_valid", 64'(bus.d_valid), 64'd0);
    chk("async f_ready", 64'(bus.f_ready), 64'd1);
    chk("async stall_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("async bubble_cnt", 64'(bus.bubble_cnt), 64'd0);
    expQ.delete();
    expStall = 0;
    expBub = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic; an unaccepted beat is held until taken or squashed.
    pend = 1'b0;
    fv = 1'b0;
    cur = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!pend) begin
        fv  = ($urandom_range(0, 9) < 7);
        cur = randBeat();
      end
      bub = ($urandom_range(0, 19) == 0);
      dr  = ($urandom_range(0, 9) < 6);
      drive(fv, cur, bub, dr, acc);
      pend = fv && !acc && !bub;
    end
    repeat (4) drive(1'b0, '0, 1'b0, 1'b1, acc);

    // Narrow counter saturates at 3.
    @(negedge clk);
    bus2.f_valid = 1'b1;
    bus2.f_valP  = 64'd5;
    @(negedge clk);
    bus2.f_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("sat stall_cnt", 64'(bus2.stall_cnt), 64'((i < 3) ? i : 3));
      chk("sat d_valid", 64'(bus2.d_valid), 64'd1);
      @(negedge clk);
    end

    #2;
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
`default_nettype wire
